// File: rtl/shift_right_seq_if.sv
// Start/ready handshake and result bus between the execute stage and the
// multicycle right shifter.
interface shift_right_seq_if;
    logic        start;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic        arith;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] out;

    modport master (
        output start, in, shamt, arith,
        input  ready, busy, done, out
    );

    modport slave (
        input  start, in, shamt, arith,
        output ready, busy, done, out
    );
endinterface

// File: rtl/shift_right_seq.sv
// Multicycle 32-bit srl/sra: one power-of-two stage (16,8,4,2,1) per clock,
// result registered on the last stage and flagged by a one-cycle done pulse.
//
// state   | meaning
// IDLE    | ready for a new operand; start accepted here only
// SHIFT   | applying stage r_stg (0..4); out written on stage 4
// DONE    | done pulse; always returns to IDLE
module shift_right_seq (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    shift_right_seq_if.slave        bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_data;
    logic [4:0]  r_amt;
    logic        r_fill;
    logic [2:0]  r_stg;
    logic [31:0] r_out;

    logic        w_active;
    logic [31:0] w_shifted;
    logic [31:0] w_stage;

    // Stage k shifts by 16>>k and is enabled by amount bit 4-k.
    always_comb begin
        w_active  = 1'b0;
        w_shifted = r_data;
        case (r_stg)
            3'd0: begin
                w_active  = r_amt[4];
                w_shifted = {{16{r_fill}}, r_data[31:16]};
            end
            3'd1: begin
                w_active  = r_amt[3];
                w_shifted = {{8{r_fill}}, r_data[31:8]};
            end
            3'd2: begin
                w_active  = r_amt[2];
                w_shifted = {{4{r_fill}}, r_data[31:4]};
            end
            3'd3: begin
                w_active  = r_amt[1];
                w_shifted = {{2{r_fill}}, r_data[31:2]};
            end
            3'd4: begin
                w_active  = r_amt[0];
                w_shifted = {r_fill, r_data[31:1]};
            end
            default: begin
                w_active  = 1'b0;
                w_shifted = r_data;
            end
        endcase
        w_stage = w_active ? w_shifted : r_data;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_data  <= 32'h0;
            r_amt   <= 5'd0;
            r_fill  <= 1'b0;
            r_stg   <= 3'd0;
            r_out   <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_data  <= bus.in;
                        r_amt   <= bus.shamt;
                        r_fill  <= bus.arith & bus.in[31];
                        r_stg   <= 3'd0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_data <= w_stage;
                    r_stg  <= r_stg + 3'd1;
                    if (r_stg == 3'd4) begin
                        r_out   <= w_stage;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status is decoded straight from state so reset takes effect immediately.
    assign bus.ready = (r_state == S_IDLE);
    assign bus.busy  = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.out   = r_out;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed and back-to-back checks of shift_right_seq against a behavioural
// srl/sra model, using a queue of expected results.
module tb_shift_right_seq;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [31:0] q[$];

    shift_right_seq_if bus ();

    shift_right_seq dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                              input logic ar);
        logic signed [31:0] sa;
        sa = a;
        if (ar) return sa >>> s;
        return a >> s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_shift(input string tag, input logic [31:0] a, input logic [4:0] s,
                            input logic ar);
        int          lat;
        logic [31:0] exp;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
        bus.start = 1'b1;
        bus.in    = a;
        bus.shamt = s;
        bus.arith = ar;
        q.push_back(ref_shift(a, s, ar));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in    = $urandom;
        bus.shamt = 5'($urandom);
        bus.arith = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 32'd6);
        exp = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
        chk({tag, "_out"}, bus.out, exp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, bus.ready}, 32'd1);
        chk({tag, "_out_hold"}, bus.out, exp);
    endtask

    initial begin
        int          pulses;
        int          last;
        logic [31:0] exp;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.in    = 32'h0;
        bus.shamt = 5'd0;
        bus.arith = 1'b0;
        #12;
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_done",  {31'd0, bus.done},  32'd0);
        chk("rst_out",   bus.out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_shift("srl31",   32'h80000000, 5'd31, 1'b0);

        // Abort a shift mid-flight; out (currently 1) must clear at once.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 32'h12345678;
        bus.shamt = 5'd3;
        bus.arith = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out",   bus.out, 32'h0);
        chk("abort_done",  {31'd0, bus.done},  32'd0);
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_busy",  {31'd0, bus.busy},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_shift("after_rst", 32'hF0F0A5A5, 5'd7,  1'b1);
        do_shift("sra4",      32'h80000000, 5'd4,  1'b1);
        do_shift("srl4",      32'h80000000, 5'd4,  1'b0);
        do_shift("zero",      32'hDEADBEEF, 5'd0,  1'b1);
        do_shift("sra31_neg", 32'h80000001, 5'd31, 1'b1);
        do_shift("sra31_pos", 32'h7FFFFFFF, 5'd31, 1'b1);
        do_shift("sra_pos",   32'h7654ABCD, 5'd13, 1'b1);
        chk("const_sra4",  ref_shift(32'h80000000, 5'd4, 1'b1), 32'hF8000000);

        // Start pulsed at E2 while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 32'h0000FF00;
        bus.shamt = 5'd8;
        bus.arith = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.in    = 32'hFFFFFFFF;
        bus.shamt = 5'd1;
        bus.arith = 1'b1;
        chk("ign_ready_low", {31'd0, bus.ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                chk("ign_out", bus.out, 32'h000000FF);
            end
        end
        chk("ign_pulses", pulses, 32'd1);
        chk("ign_hold",   bus.out, 32'h000000FF);

        // Back-to-back with start held high.
        last = -1;
        for (int c = 0; c < 75; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (q.size() == 0) chk("b2b_unexpected_done", 32'd1, 32'd0);
                else begin
                    exp = q.pop_front();
                    chk("b2b_out", bus.out, exp);
                end
            end
            bus.in    = $urandom;
            bus.shamt = 5'($urandom);
            bus.arith = 1'($urandom);
            if (bus.ready) begin
                if (last >= 0) chk("b2b_interval", c - last, 32'd7);
                last = c;
                q.push_back(ref_shift(bus.in, bus.shamt, bus.arith));
            end
            bus.start = 1'b1;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (q.size() == 0) chk("b2b_unexpected_done", 32'd1, 32'd0);
                else begin
                    exp = q.pop_front();
                    chk("b2b_out", bus.out, exp);
                end
            end
            bus.start = 1'b0;
        end
        chk("b2b_drain", q.size(), 32'd0);
        chk("b2b_seen", (last >= 0) ? 32'd1 : 32'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Multicycle 32-bit right shifter for the processor's shift datapath. It complements the existing fixed left-shift stages and supports both logical (srl) and arithmetic (sra) right shifts. A shift is decomposed into the five power-of-two stages (16, 8, 4, 2, 1) and one stage is applied per clock. The execute stage starts a shift with a start/ready handshake and receives a one-cycle done pulse with a registered result.

## Interface
- No parameters. Data width is fixed at 32 and shift amount at 5 bits.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while ready=1.
- in  input  32  operand; captured on the accepted start edge.
- shamt  input  5  shift amount 0-31; captured with in.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured with in.
- ready  output  1  high in IDLE; decoded from state.
- busy  output  1  high in SHIFT or DONE.
- done  output  1  one-cycle pulse; out is valid from this cycle.
- out  output  32  registered result; holds until the next result is written.

## Operation
- State machine has three states: IDLE, SHIFT, DONE. Internal registers are data[31:0], amt[4:0], fill, and a stage counter stg[2:0].
- IDLE, with start=1 (accepted edge):
  - data<=in, amt<=shamt, fill<=arith&in[31], stg<=0.
  - Next state is SHIFT.
- IDLE, with start=0: remain in IDLE.
- SHIFT, each edge:
  - Stage stg selects a distance d: stg 0->16, 1->8, 2->4, 3->2, 4->1.
  - The stage is active when amt[4-stg]=1.
  - If active, data<={{d{fill}}, data[31:d]}; otherwise data is unchanged. stg<=stg+1.
  - On the stg=4 edge, out<=the stage result and the next state is DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE unconditionally.
- start is ignored while busy=1. It is not queued. A start held high across DONE is accepted on the first IDLE edge after it.
- shamt=0 still takes the full latency, and out=in.
- When arith=1 and in[31]=0, the result equals the logical shift.
- shamt=31 with arith=1 gives 32'hFFFFFFFF if in[31]=1, else 0.
- out changes only on the stg=4 edge and on reset.

## Timing
- Reset (reset_n=0, asynchronous) forces:
  - state IDLE, ready=1, busy=0, done=0, out=32'h0.
  - data, amt, fill, stg cleared to 0.
- Reset asserted mid-operation aborts the shift immediately. No done pulse is produced, and out returns to 0.
- Edge E0 accepts start. Edges E1-E5 apply the five stages, and E5 also writes out. done is high in the cycle after E5, i.e. 6 edges after start is sampled.
- The next start can be accepted at E7 (DONE->IDLE occurs at E6). Back-to-back throughput is one shift per 7 cycles.
- ready falls the cycle after E0 and rises the cycle after E6.
- Operand inputs may change freely after E0.

## Test plan
- Reset behaviour: assert reset_n=0 mid-SHIFT.
  - Required: out=0, done=0 and ready=1 immediately (before the next edge).
  - After release, a new shift completes normally.
- Logical shift: in=32'h80000000, shamt=31, arith=0.
  - Required: done 6 edges after start, out=32'h00000001.
- Arithmetic shift: in=32'h80000000, shamt=4, arith=1.
  - Required: out=32'hF8000000.
  - Required: the same operands with arith=0 give 32'h08000000.
- Zero shift: in=32'hDEADBEEF, shamt=0, arith=1.
  - Required: out=32'hDEADBEEF after the full 6-edge latency, single done pulse.
- Busy ignore: start a shift with in=32'h0000FF00, shamt=8, arith=0. Pulse start at E2 with different operands.
  - Required: out=32'h000000FF and exactly one done pulse.
  - Required: out holds its value through IDLE.
- Back-to-back: hold start=1 continuously with a random operand stream.
  - Required: accept every 7th edge, and each out matches the reference model (srl/sra of the operands captured at acceptance).
